clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Bank of `N_CH` independent programmable clock dividers, all driven from one system clock. Each channel produces a 50%-duty divided clock and a one-cycle tick strobe. Each channel's divisor is written at run time, and a new divisor takes effect only at a half-period boundary, so switching is glitch-free. The bank sits between the board clock and the slow-clock consumers: blinkers, debouncers, display scanners and step generators. It replaces fixed, per-use divider instances.

## Interface
Parameters:
- `N_CH`, 4: number of divider channels (1..16).
- `CNT_W`, 28: counter and divisor width in bits.
- `DEF_DIV`, 50000000: divisor loaded into every channel at reset.

Ports:
- `clk`, in, 1: system clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `wr_en`, in, 1: divisor write strobe, one cycle per write.
- `wr_ch`, in, `$clog2(N_CH)` (minimum 1): channel index for the write.
- `wr_div`, in, `CNT_W`: new divisor value. A value of 0 disables the channel.
- `sync`, in, 1: phase-align pulse. Present only with `CLK_DIV_BANK_SYNC_EN`.
- `outclk`, out, `N_CH`: divided clock, one bit per channel.
- `tick`, out, `N_CH`: one-cycle strobe on every `outclk` edge.
- `pending`, out, `N_CH`: a written divisor is waiting for its boundary.

## Operation
Each channel holds the following state:
- active divisor `act`;
- pending divisor `pnd` and its valid flag `pending`;
- counter `cnt`;
- `outclk`, `tick`.

Write path:
- `wr_en` with `wr_ch` < `N_CH` sets `pnd` ← `wr_div` and `pending` ← 1.
- A second write before the boundary overwrites `pnd`; the last write wins.
- `wr_ch` ≥ `N_CH` is ignored, and no state changes.

Per-channel step, evaluated every cycle with `act` ≠ 0:
- If `cnt` == `act` (boundary): toggle `outclk`, `cnt` ← 0, `tick` ← 1. If `pending` is set, `act` ← `pnd` and `pending` ← 0.
- Otherwise: `cnt` ← `cnt`+1 and `tick` ← 0.
- Half-period is `act`+1 cycles, so the full period is 2·(`act`+1) cycles.

Disabled channel (`act` == 0):
- `cnt` ← 0, `outclk` ← 0, `tick` ← 0.
- A pending divisor is applied on the next cycle, immediately, with no boundary wait. The channel then restarts with `cnt`=0 and `outclk`=0.

Simultaneous write and boundary on the same channel:
- The written value is applied directly to `act` at that boundary.
- `pending` stays 0 afterwards.

Writing 0 to a running channel:
- Takes effect at the next boundary.
- `outclk` then stays low. If the boundary toggle would have left `outclk` high, it is forced to 0 instead and `tick` still pulses.

Arithmetic:
- `cnt` is an unsigned `CNT_W`-bit counter and never exceeds `act`, so it cannot wrap.
- The maximum divisor is 2^`CNT_W`−1.

## Timing
Reset (`rst_n`=0 at a rising edge):
- `cnt`=0, `act`=`DEF_DIV`, `pending`=0, `outclk`=0, `tick`=0, on every channel.
- Reset mid-period discards any pending write.

Latency:
- Write to `pending` visible: 1 cycle.
- `tick` is registered and asserts in the same cycle `outclk` changes.
- After reset, the first `outclk` rise occurs on the `DEF_DIV`+1-th rising edge following reset release.

Channels are fully independent; there are no cross-channel interactions except `sync`.

## Configuration
- `CLK_DIV_BANK_SYNC_EN` defined:
  - The `sync` port exists.
  - `sync`=1 makes every channel set `cnt` ← 0, `outclk` ← 0, `tick` ← 0, and apply any pending divisor at once.
  - If `wr_en` is high in the same cycle, that write is applied too.
  - `rst_n`=0 has priority over `sync`.
- Macro not defined: no `sync` port and no alignment logic. Channel phases depend only on reset and write history.

## Structure
- Package `clk_div_pkg`: default `CNT_W`, constant `DIV_DISABLE` = 0, and the channel-state struct typedef (`act`, `pnd`, `pending`, `cnt`).
- Sub-module `clk_div_chan`: one channel (counter, divisor registers, boundary logic), instantiated `N_CH` times in a generate loop.
- The top level decodes `wr_ch` into per-channel write enables and fans out `sync`.

## Test plan
1. Reset with `DEF_DIV`=3 and no writes: every `outclk` toggles every 4 cycles (period 8). `tick` pulses once per toggle, and the first rise is on the 4th edge after reset release.
2. On channel 1 running at `act`=3, write 1 at `cnt`=1: `pending`=1 until the boundary. The current half-period still completes in 4 cycles, then subsequent half-periods are 2 cycles, with no runt pulse.
3. On channel 2 at a boundary, apply `wr_en` with `wr_div`=5 in the boundary cycle: `act`=5 immediately, `pending` stays 0, and the next half-period is 6 cycles.
4. Write 0 to channel 0 while `outclk`=1: at the next boundary `outclk` becomes 0 and holds. Then write 2: running resumes the next cycle with half-period 3.
5. Write with `wr_ch`=`N_CH` (out of range): no `pending` bit sets and all outputs are unchanged. Then assert `rst_n`=0 mid-period: all outputs return to 0 and `act` returns to `DEF_DIV`.
6. With `CLK_DIV_BANK_SYNC_EN`, channels at different phases and divisors 2/3/4/5, pulse `sync`: all `outclk`=0 and `cnt`=0 the next cycle. The first rises follow at 3, 4, 5 and 6 cycles respectively.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_bank divider bank.
// Channel state is held at MAX_CNT_W bits; CNT_W-bit divisors are zero-extended into it.
package clk_div_pkg;

    localparam int DEF_CNT_W = 28;
    localparam int MAX_CNT_W = 32;

    typedef logic [MAX_CNT_W-1:0] div_word_t;

    localparam div_word_t DIV_DISABLE = '0;

    typedef struct packed {
        div_word_t act;
        div_word_t pnd;
        logic      pending;
        div_word_t cnt;
    } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One glitch-free programmable divider channel: divisor registers, counter and boundary logic.
// Optional phase-align input enabled by CLK_DIV_BANK_SYNC_EN.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic             sync,
`endif
    output logic             outclk,
    output logic             tick,
    output logic             pending
);

    chan_state_t st;
    logic        out_q;
    logic        tick_q;
    div_word_t   wdiv;
    div_word_t   next_act;

    assign wdiv = div_word_t'(wr_div);

    // A write landing on the boundary cycle beats any older pending value.
    assign next_act = wr ? wdiv : (st.pending ? st.pnd : st.act);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st.act     <= div_word_t'(DEF_DIV);
            st.pnd     <= '0;
            st.pending <= 1'b0;
            st.cnt     <= '0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
        end
`ifdef CLK_DIV_BANK_SYNC_EN
        else if (sync) begin
            st.cnt     <= '0;
            st.pending <= 1'b0;
            st.act     <= next_act;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
        end
`endif
        else if (st.act == DIV_DISABLE) begin
            // Disabled: hold low and pick up a pending divisor without waiting.
            st.cnt <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            if (st.pending) begin
                st.act <= st.pnd;
            end
            if (wr) begin
                st.pnd     <= wdiv;
                st.pending <= 1'b1;
            end else begin
                st.pending <= 1'b0;
            end
        end else if (st.cnt == st.act) begin
            st.cnt     <= '0;
            st.act     <= next_act;
            st.pending <= 1'b0;
            tick_q     <= 1'b1;
            out_q      <= (next_act == DIV_DISABLE) ? 1'b0 : ~out_q;
        end else begin
            st.cnt <= st.cnt + 1'b1;
            tick_q <= 1'b0;
            if (wr) begin
                st.pnd     <= wdiv;
                st.pending <= 1'b1;
            end
        end
    end

    assign outclk  = out_q;
    assign tick    = tick_q;
    assign pending = st.pending;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent glitch-free clock dividers sharing one system clock.
// Define CLK_DIV_BANK_SYNC_EN to add the 'sync' phase-align port.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int CNT_W   = DEF_CNT_W,
    parameter  int DEF_DIV = 50000000,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic             sync,
`endif
    output logic [N_CH-1:0]  outclk,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    logic [N_CH-1:0] ch_wr;

    // Indices at or above N_CH match no channel, so such writes fall away.
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        localparam logic [CH_W-1:0] IDX = CH_W'(g);

        assign ch_wr[g] = wr_en && (wr_ch == IDX);

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (ch_wr[g]),
            .wr_div  (wr_div),
`ifdef CLK_DIV_BANK_SYNC_EN
            .sync    (sync),
`endif
            .outclk  (outclk[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus random writes against a reference model.
// Exercises the sync port when CLK_DIV_BANK_SYNC_EN is defined.
module tb_clk_div_bank;

    localparam int N_CH    = 5;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 3;
    localparam int CH_W    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [CH_W-1:0]  wr_ch = '0;
    logic [CNT_W-1:0] wr_div = '0;
`ifdef CLK_DIV_BANK_SYNC_EN
    logic             sync = 1'b0;
`endif
    logic [N_CH-1:0]  outclk;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  pending;

    int vectors = 0;
    int miscompares = 0;

    // Reference model, phrased as "half-period length" and "cycles left before the next edge".
    int m_half [N_CH];
    int m_left [N_CH];
    int m_next [N_CH];
    bit m_out  [N_CH];
    bit m_tick [N_CH];
    bit m_pend [N_CH];

    always #5 clk = ~clk;

    clk_div_bank #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
`ifdef CLK_DIV_BANK_SYNC_EN
        .sync    (sync),
`endif
        .outclk  (outclk),
        .tick    (tick),
        .pending (pending)
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit we, input int ch, input int div, input bit sy);
        for (int c = 0; c < N_CH; c++) begin
            bit w;
            w = we && (ch == c);
            if (rst) begin
                m_half[c] = DEF_DIV;
                m_left[c] = DEF_DIV;
                m_out[c]  = 0;
                m_tick[c] = 0;
                m_pend[c] = 0;
            end else if (sy) begin
                m_half[c] = w ? div : (m_pend[c] ? m_next[c] : m_half[c]);
                m_left[c] = m_half[c];
                m_pend[c] = 0;
                m_out[c]  = 0;
                m_tick[c] = 0;
            end else if (m_half[c] == 0) begin
                m_out[c]  = 0;
                m_tick[c] = 0;
                if (m_pend[c]) m_half[c] = m_next[c];
                m_left[c] = m_half[c];
                m_pend[c] = w;
                if (w) m_next[c] = div;
            end else if (m_left[c] == 0) begin
                m_half[c] = w ? div : (m_pend[c] ? m_next[c] : m_half[c]);
                m_left[c] = m_half[c];
                m_pend[c] = 0;
                m_tick[c] = 1;
                m_out[c]  = (m_half[c] == 0) ? 1'b0 : !m_out[c];
            end else begin
                m_left[c] = m_left[c] - 1;
                m_tick[c] = 0;
                if (w) begin
                    m_next[c] = div;
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare shortly after.
    task automatic applyStimulus(input bit rst, input bit we, input int ch, input int div, input bit sy);
        logic [N_CH-1:0] e_out, e_tick, e_pend;
        @(negedge clk);
        rst_n  = !rst;
        wr_en  = we;
        wr_ch  = CH_W'(ch);
        wr_div = CNT_W'(div);
`ifdef CLK_DIV_BANK_SYNC_EN
        sync   = sy;
`endif
        @(posedge clk);
        model_step(rst, we, ch, div, sy);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            e_out[c]  = m_out[c];
            e_tick[c] = m_tick[c];
            e_pend[c] = m_pend[c];
        end
        checkOutput("outclk", int'(outclk), int'(e_out));
        checkOutput("tick", int'(tick), int'(e_tick));
        checkOutput("pending", int'(pending), int'(e_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            m_next[c] = 0;
        end

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_outclk", int'(outclk), 0);
        checkOutput("reset_pending", int'(pending), 0);

        // Edges counted from reset release; all channels start at DEF_DIV=3.
        idle(1);                                   // edge 1
        applyStimulus(0, 1, 1, 1, 0);              // edge 2: ch1 <- 1 while cnt=1
        checkOutput("ch1_pending", int'(pending[1]), 1);
        idle(1);                                   // edge 3
        checkOutput("no_rise_edge3", int'(outclk), 0);
        applyStimulus(0, 1, 2, 5, 0);              // edge 4: boundary write on ch2
        checkOutput("first_rise_edge4", int'(outclk), 5'b11111);
        checkOutput("first_tick_edge4", int'(tick), 5'b11111);
        checkOutput("ch2_no_pending", int'(pending[2]), 0);
        applyStimulus(0, 1, 0, 0, 0);              // edge 5: disable ch0 while high
        idle(1);                                   // edge 6
        checkOutput("ch1_fast_fall", int'(outclk[1]), 0);
        idle(2);                                   // edges 7, 8
        checkOutput("ch0_forced_low", int'(outclk[0]), 0);
        checkOutput("ch0_tick_at_disable", int'(tick[0]), 1);
        checkOutput("ch3_fall_edge8", int'(outclk[3]), 0);
        idle(1);                                   // edge 9
        checkOutput("ch2_high_edge9", int'(outclk[2]), 1);
        idle(1);                                   // edge 10
        checkOutput("ch2_fall_edge10", int'(outclk[2]), 0);
        idle(1);                                   // edge 11
        checkOutput("ch0_holds_low", int'(outclk[0]), 0);
        applyStimulus(0, 1, 0, 2, 0);              // edge 12: re-enable ch0 with 2
        idle(3);                                   // edges 13..15
        checkOutput("ch0_low_edge15", int'(outclk[0]), 0);
        idle(1);                                   // edge 16
        checkOutput("ch0_rise_edge16", int'(outclk[0]), 1);

        applyStimulus(0, 1, N_CH, 1, 0);           // out-of-range channel
        checkOutput("oor_no_pending", int'(pending), 0);
        idle(2);
        applyStimulus(0, 1, 3, 6, 0);
        applyStimulus(1, 0, 0, 0, 0);              // reset mid-period
        checkOutput("midreset_outclk", int'(outclk), 0);
        checkOutput("midreset_pending", int'(pending), 0);
        idle(4);
        checkOutput("rerise_edge4", int'(outclk), 5'b11111);

        for (int i = 0; i < 3000; i++) begin
            bit rst, we, sy;
            int ch, div;
            rst = ($urandom_range(0, 199) == 0);
            we  = ($urandom_range(0, 3) == 0);
            ch  = $urandom_range(0, 7);
            div = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
`ifdef CLK_DIV_BANK_SYNC_EN
            sy  = ($urandom_range(0, 59) == 0);
`else
            sy  = 0;
`endif
            applyStimulus(rst, we, ch, div, sy);
        end

`ifdef CLK_DIV_BANK_SYNC_EN
        applyStimulus(1, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 1, c, c + 2, 0);
            idle(c + 1);
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("sync_outclk", int'(outclk), 0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            for (int c = 0; c < 4; c++) begin
                if (k == c + 2) checkOutput($sformatf("sync_low_ch%0d", c), int'(outclk[c]), 0);
                if (k == c + 3) checkOutput($sformatf("sync_rise_ch%0d", c), int'(outclk[c]), 1);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
